// File: rtl/ps2_rx_frame.sv
// ---------------------------------------------------------------------------
// ps2_rx_frame
//   Receives PS/2 keyboard frames (start, 8 data LSB-first, odd parity, stop)
//   from the raw pins and presents each good byte with a one-cycle strobe for
//   the move decoder. Rejected or stalled frames produce a one-cycle error
//   strobe instead.
//
// Ports
//   CLOCK_50  in   system clock (50 MHz)
//   reset     in   synchronous reset, active-high
//   ps2_clk   in   raw PS/2 clock pin (asynchronous)
//   ps2_dat   in   raw PS/2 data pin (asynchronous)
//   scancode  out  [7:0] last correctly received byte, held between frames
//   ps2_rec   out  one-cycle strobe, scancode valid in this cycle
//   frame_err out  one-cycle strobe for a bad start/parity/stop or a timeout
// ---------------------------------------------------------------------------
module ps2_rx_frame #(
  parameter int FILTER_LEN  = 8,
  parameter int TIMEOUT_CYC = 100000
) (
  input  logic       CLOCK_50,
  input  logic       reset,
  input  logic       ps2_clk,
  input  logic       ps2_dat,
  output logic [7:0] scancode,
  output logic       ps2_rec,
  output logic       frame_err
);

  localparam int FW = $clog2(FILTER_LEN + 1);
  localparam int TW = $clog2(TIMEOUT_CYC + 1);
  localparam logic [FW-1:0] FILTER_LAST = FW'(FILTER_LEN - 1);
  localparam logic [TW-1:0] TIMEOUT_LAST = TW'(TIMEOUT_CYC - 1);

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_DATA,
    ST_PARITY,
    ST_STOP
  } state_t;

  // Two-flop synchronisers for both pins (idle level of the bus is 1).
  logic          clk_s1_q, clk_s1_d, clk_s2_q, clk_s2_d;
  logic          dat_s1_q, dat_s1_d, dat_s2_q, dat_s2_d;
  // Glitch filter.
  logic          filt_clk_q, filt_clk_d;
  logic [FW-1:0] filt_cnt_q, filt_cnt_d;
  // Frame FSM and datapath.
  state_t        state_q, state_d;
  logic [2:0]    bit_cnt_q, bit_cnt_d;
  logic [7:0]    shift_q, shift_d;
  logic          par_q, par_d;
  logic [TW-1:0] to_cnt_q, to_cnt_d;
  // Registered outputs.
  logic [7:0]    scancode_q, scancode_d;
  logic          rec_q, rec_d;
  logic          err_q, err_d;

  logic          sample_evt;

  always_comb begin
    // NOTE: every signal gets a default before any branch so no path can
    // leave it unassigned, which would otherwise infer a latch.
    clk_s1_d   = ps2_clk;
    clk_s2_d   = clk_s1_q;
    dat_s1_d   = ps2_dat;
    dat_s2_d   = dat_s1_q;

    filt_clk_d = filt_clk_q;
    filt_cnt_d = '0;
    state_d    = state_q;
    bit_cnt_d  = bit_cnt_q;
    shift_d    = shift_q;
    par_d      = par_q;
    scancode_d = scancode_q;
    rec_d      = 1'b0;
    err_d      = 1'b0;

    // The filtered clock only follows the synced clock after it has held
    // its new level for FILTER_LEN consecutive cycles.
    if (clk_s2_q != filt_clk_q) begin
      if (filt_cnt_q == FILTER_LAST) filt_clk_d = clk_s2_q;
      else                           filt_cnt_d = filt_cnt_q + 1'b1;
    end

    // Falling edge of the filtered clock, seen in the cycle it is decided.
    sample_evt = filt_clk_q & ~filt_clk_d;

    // Stall watchdog: only runs while a frame is in progress.
    if (sample_evt || state_q == ST_IDLE) to_cnt_d = '0;
    else                                  to_cnt_d = to_cnt_q + 1'b1;

    if (sample_evt) begin
      unique case (state_q)
        ST_IDLE: begin
          if (!dat_s2_q) begin
            state_d   = ST_DATA;
            bit_cnt_d = '0;
          end else begin
            err_d     = 1'b1;   // bad start bit
          end
        end
        ST_DATA: begin
          shift_d[bit_cnt_q] = dat_s2_q;
          bit_cnt_d          = bit_cnt_q + 1'b1;
          if (bit_cnt_q == 3'd7) state_d = ST_PARITY;
        end
        ST_PARITY: begin
          par_d   = dat_s2_q;
          state_d = ST_STOP;
        end
        ST_STOP: begin
          // Odd parity: XOR over data plus parity bit must be 1.
          if ((^{shift_q, par_q}) && dat_s2_q) begin
            scancode_d = shift_q;
            rec_d      = 1'b1;
          end else begin
            err_d      = 1'b1;
          end
          state_d = ST_IDLE;
        end
        default: state_d = ST_IDLE;
      endcase
    end else if (state_q != ST_IDLE && to_cnt_q == TIMEOUT_LAST) begin
      // A sample event in the expiry cycle takes the branch above instead.
      state_d   = ST_IDLE;
      bit_cnt_d = '0;
      err_d     = 1'b1;
    end
  end

  // Single register process for all state, including the FSM.
  always_ff @(posedge CLOCK_50) begin
    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples the pre-edge value regardless of statement order.
    if (reset) begin
      clk_s1_q   <= 1'b1;
      clk_s2_q   <= 1'b1;
      dat_s1_q   <= 1'b1;
      dat_s2_q   <= 1'b1;
      filt_clk_q <= 1'b1;
      filt_cnt_q <= '0;
      state_q    <= ST_IDLE;
      bit_cnt_q  <= '0;
      shift_q    <= '0;
      par_q      <= 1'b0;
      to_cnt_q   <= '0;
      scancode_q <= 8'h00;
      rec_q      <= 1'b0;
      err_q      <= 1'b0;
    end else begin
      clk_s1_q   <= clk_s1_d;
      clk_s2_q   <= clk_s2_d;
      dat_s1_q   <= dat_s1_d;
      dat_s2_q   <= dat_s2_d;
      filt_clk_q <= filt_clk_d;
      filt_cnt_q <= filt_cnt_d;
      state_q    <= state_d;
      bit_cnt_q  <= bit_cnt_d;
      shift_q    <= shift_d;
      par_q      <= par_d;
      to_cnt_q   <= to_cnt_d;
      scancode_q <= scancode_d;
      rec_q      <= rec_d;
      err_q      <= err_d;
    end
  end

  assign scancode  = scancode_q;
  assign ps2_rec   = rec_q;
  assign frame_err = err_q;

endmodule

// File: tb/tb_ps2_rx_frame.sv
// ---------------------------------------------------------------------------
// tb_ps2_rx_frame
//   Directed frames against ps2_rx_frame. The PS/2 clock is scaled down to an
//   80-cycle period and the timeout shortened so the run stays small; both
//   are still far longer than the glitch filter.
// ---------------------------------------------------------------------------
module tb_ps2_rx_frame;

  localparam int FILTER_LEN  = 8;
  localparam int TIMEOUT_CYC = 2000;
  localparam int HALF        = 40;

  logic       CLOCK_50 = 1'b0;
  logic       reset    = 1'b1;
  logic       ps2_clk  = 1'b1;
  logic       ps2_dat  = 1'b1;
  logic [7:0] scancode;
  logic       ps2_rec;
  logic       frame_err;

  ps2_rx_frame #(
    .FILTER_LEN (FILTER_LEN),
    .TIMEOUT_CYC(TIMEOUT_CYC)
  ) dut (
    .CLOCK_50 (CLOCK_50),
    .reset    (reset),
    .ps2_clk  (ps2_clk),
    .ps2_dat  (ps2_dat),
    .scancode (scancode),
    .ps2_rec  (ps2_rec),
    .frame_err(frame_err)
  );

  always #10 CLOCK_50 = ~CLOCK_50;

  int n_vec  = 0;
  int n_miss = 0;
  int cyc    = 0;
  int rec_cnt = 0, err_cnt = 0, both_cnt = 0;
  int err_cyc = 0, last_fall = 0;
  logic [7:0] rec_codes[$];

  always @(posedge CLOCK_50) cyc <= cyc + 1;

  // Strobe monitor, sampled away from the active edge.
  always @(negedge CLOCK_50) begin
    if (!reset) begin
      if (ps2_rec) begin
        rec_cnt++;
        rec_codes.push_back(scancode);
      end
      if (frame_err) begin
        err_cnt++;
        err_cyc = cyc;
      end
      if (ps2_rec && frame_err) both_cnt++;
    end
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_miss++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic wait_cyc(input int n);
    repeat (n) @(negedge CLOCK_50);
  endtask

  task automatic send_bit(input logic b);
    @(negedge CLOCK_50);
    ps2_dat = b;
    wait_cyc(HALF);
    ps2_clk   = 1'b0;
    last_fall = cyc;
    wait_cyc(HALF);
    ps2_clk = 1'b1;
  endtask

  task automatic send_frame(input logic [7:0] d, input logic par, input logic stp);
    send_bit(1'b0);
    for (int i = 0; i < 8; i++) send_bit(d[i]);
    send_bit(par);
    send_bit(stp);
    ps2_dat = 1'b1;
  endtask

  task automatic settle();
    wait_cyc(4 * HALF);
    #1;
  endtask

  int r0, e0;

  initial begin
    wait_cyc(5);
    reset = 1'b0;
    wait_cyc(3);
    #1;
    check("reset_scancode", 32'(scancode), 32'h00);
    check("reset_rec", 32'(ps2_rec), 0);
    check("reset_err", 32'(frame_err), 0);

    // 0x2B with wrong parity: rejected, scancode keeps its reset value.
    r0 = rec_cnt; e0 = err_cnt;
    send_frame(8'h2B, 1'b0, 1'b1);
    settle();
    check("badpar_err", 32'(err_cnt - e0), 1);
    check("badpar_rec", 32'(rec_cnt - r0), 0);
    check("badpar_code", 32'(scancode), 32'h00);

    // 0x2B correct.
    r0 = rec_cnt; e0 = err_cnt;
    send_frame(8'h2B, 1'b1, 1'b1);
    settle();
    check("2b_rec", 32'(rec_cnt - r0), 1);
    check("2b_err", 32'(err_cnt - e0), 0);
    check("2b_code", 32'(scancode), 32'h2B);

    // 0x32 with bad stop bit, then 0x4B.
    r0 = rec_cnt; e0 = err_cnt;
    send_frame(8'h32, 1'b0, 1'b0);
    settle();
    check("badstop_err", 32'(err_cnt - e0), 1);
    check("badstop_rec", 32'(rec_cnt - r0), 0);
    check("badstop_code", 32'(scancode), 32'h2B);
    send_frame(8'h4B, 1'b1, 1'b1);
    settle();
    check("4b_code", 32'(scancode), 32'h4B);

    // 3-cycle low glitch in IDLE is filtered out, then 0x23.
    r0 = rec_cnt; e0 = err_cnt;
    @(negedge CLOCK_50);
    ps2_clk = 1'b0;
    wait_cyc(3);
    ps2_clk = 1'b1;
    settle();
    check("glitch_err", 32'(err_cnt - e0), 0);
    send_frame(8'h23, 1'b0, 1'b1);
    settle();
    check("23_rec", 32'(rec_cnt - r0), 1);
    check("23_code", 32'(scancode), 32'h23);
    check("23_err", 32'(err_cnt - e0), 0);

    // Start + 4 data bits then stall: timeout error, then 0xF0.
    r0 = rec_cnt; e0 = err_cnt;
    send_bit(1'b0);
    send_bit(1'b1);
    send_bit(1'b0);
    send_bit(1'b1);
    send_bit(1'b1);
    ps2_dat = 1'b1;
    for (int i = 0; i < TIMEOUT_CYC + 200 && err_cnt == e0; i++) wait_cyc(1);
    #1;
    check("to_err", 32'(err_cnt - e0), 1);
    // 2 sync + FILTER_LEN filter cycles to the event, TIMEOUT_CYC counts,
    // and the output register stage.
    check("to_delay", 32'(err_cyc - last_fall), 32'(TIMEOUT_CYC + 10));
    check("to_rec", 32'(rec_cnt - r0), 0);
    send_frame(8'hF0, 1'b1, 1'b1);
    settle();
    check("f0_code", 32'(scancode), 32'hF0);

    // Back-to-back frames with no idle gap.
    r0 = rec_cnt;
    rec_codes.delete();
    send_frame(8'hF0, 1'b1, 1'b1);
    send_frame(8'h2B, 1'b1, 1'b1);
    settle();
    check("b2b_rec", 32'(rec_cnt - r0), 2);
    check("b2b_first", 32'((rec_codes.size() > 0) ? rec_codes[0] : 8'hxx), 32'hF0);
    check("b2b_second", 32'((rec_codes.size() > 1) ? rec_codes[1] : 8'hxx), 32'h2B);

    // Data line high at a falling edge in IDLE: bad start.
    e0 = err_cnt;
    send_bit(1'b1);
    settle();
    check("badstart_err", 32'(err_cnt - e0), 1);

    // Reset in the middle of a frame.
    r0 = rec_cnt; e0 = err_cnt;
    send_bit(1'b0);
    send_bit(1'b1);
    send_bit(1'b1);
    send_bit(1'b0);
    @(negedge CLOCK_50);
    reset = 1'b1;
    wait_cyc(3);
    #1;
    check("rst_code", 32'(scancode), 32'h00);
    check("rst_rec", 32'(ps2_rec), 0);
    check("rst_err", 32'(frame_err), 0);
    @(negedge CLOCK_50);
    reset = 1'b0;
    wait_cyc(TIMEOUT_CYC + 100);
    #1;
    check("rst_no_rec", 32'(rec_cnt - r0), 0);
    check("rst_no_err", 32'(err_cnt - e0), 0);
    check("rst_code_after", 32'(scancode), 32'h00);

    check("never_both", 32'(both_cnt), 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule

// File: doc/ps2_rx_frame.md
Name: ps2_rx_frame

Overview:
- Upstream stage of the keyboard move-control path.
- Deserialises raw PS/2 keyboard clock/data lines into 8-bit scancodes.
- Emits the scancode with a single-cycle receive strobe that feeds the scancode/ps2_rec inputs of the move decoder.
- Handles line synchronisation, clock glitch filtering, odd-parity and stop-bit checking, and recovery from stalled frames.

Parameters:
- FILTER_LEN, 8: consecutive CLOCK_50 cycles the synchronised ps2_clk must be stable before the filtered clock changes.
- TIMEOUT_CYC, 100000: idle CLOCK_50 cycles between filtered falling edges before a partial frame is abandoned (2 ms at 50 MHz).

Ports:
- CLOCK_50 input 1: system clock, 50 MHz.
- reset input 1: synchronous reset, active-high.
- ps2_clk input 1: raw PS/2 clock from the pin, asynchronous.
- ps2_dat input 1: raw PS/2 data from the pin, asynchronous.
- scancode output 8: last correctly received byte; held between frames.
- ps2_rec output 1: one-cycle strobe; scancode is valid in this cycle.
- frame_err output 1: one-cycle strobe on any rejected or abandoned frame.

Behaviour:
- Reset state:
  - scancode=8'h00, ps2_rec=0, frame_err=0.
  - FSM=IDLE, bit counter=0, timeout counter=0.
  - Synchroniser flops=1, filtered clock=1.
  - Reset mid-frame discards the partial frame with no strobe.
- Synchronisation: ps2_clk and ps2_dat each pass through 2 flops before any use.
- Clock filter:
  - Counter increments while synced clk differs from filtered clk; it clears when they match.
  - Filtered clk takes the synced value when the counter reaches FILTER_LEN-1.
  - Pulses shorter than FILTER_LEN cycles are ignored.
- Sample event:
  - The cycle in which filtered clk goes 1->0.
  - Synced ps2_dat is sampled in that cycle.
- FSM, acting only on sample events except for timeout:
  - IDLE: dat=0 -> DATA with bit count 0. dat=1 -> stay IDLE and pulse frame_err (bad start).
  - DATA: shift dat into bit[count], LSB first. After the 8th bit (count=7) -> PARITY.
  - PARITY: store the parity bit, then -> STOP.
  - STOP, parity OK and dat=1: scancode<=shift register, ps2_rec=1 next cycle.
  - STOP, otherwise: frame_err=1 next cycle and scancode unchanged.
  - STOP always returns to IDLE.
- Parity rule: ones count over the 8 data bits plus the parity bit must be odd.
- Latency:
  - ps2_rec and scancode update in the cycle immediately after the STOP sample event.
  - Pin-to-event delay is 2 sync cycles plus FILTER_LEN filter cycles.
- Strobes:
  - ps2_rec and frame_err are high for exactly 1 cycle.
  - They are never both high in the same cycle.
  - They default to 0 every other cycle.
- Timeout:
  - Counter clears on every sample event and while in IDLE; otherwise it increments.
  - At TIMEOUT_CYC-1 outside IDLE: FSM -> IDLE, frame_err pulses, partial data is discarded.
  - A sample event in the same cycle as expiry wins; the timeout does not fire.
- Back-to-back frames: supported. A new start bit is accepted on the first sample event after STOP.
- No host-to-device transmission. ps2_clk and ps2_dat are input-only.

Test Plan:
- Frame 0x2B: start 0, data LSB-first 1,1,0,1,0,1,0,0, parity 1, stop 1, at a 10 kHz PS/2 clock -> ps2_rec high for 1 cycle, scancode=8'h2B, frame_err never high.
- Same frame with parity 0 -> frame_err high for 1 cycle, ps2_rec never high, scancode retains the prior value 8'h00.
- Frame 0x32 with stop bit 0 -> frame_err pulse, no ps2_rec; next valid frame 0x4B (parity 1) -> scancode=8'h4B.
- ps2_clk glitched low for 3 cycles in IDLE (FILTER_LEN=8), then valid frame 0x23 -> no frame_err from the glitch; scancode=8'h23 with exactly one ps2_rec.
- Send start plus 4 data bits, then hold ps2_clk high -> frame_err pulses TIMEOUT_CYC cycles after the last edge; following frame 0xF0 (parity 1) -> scancode=8'hF0.
- Back-to-back 0xF0 then 0x2B, and reset asserted mid-frame in a separate run:
  - Back-to-back -> two ps2_rec pulses with scancode 8'hF0 then 8'h2B.
  - Reset mid-frame -> all outputs 0 and no strobe from the truncated frame.
